fifo_read_ctrl: RTL and testbench
=================================

# fifo_read_ctrl

Read-side controller that drains a fixed number of words from the synchronous FIFO and presents them on a valid/ready stream interface. It issues `rd_en` only when the FIFO is non-empty and local buffer space is guaranteed. It absorbs the FIFO's one-cycle read latency in a 3-entry output buffer, so it sustains one word per cycle under continuous `m_ready`. It sits between the FIFO's read port and the downstream consumer.

## Interface
- `DATA_WIDTH`, 16, width of FIFO read data and stream data
- `LEN_WIDTH`, 8, width of transfer length / remaining counters
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a transfer; sampled only in IDLE
- `len`  in  LEN_WIDTH  number of words to transfer; sampled with `start`
- `busy`  out  1  high while state is not IDLE
- `done`  out  1  one-cycle pulse when a transfer completes
- `words_left`  out  LEN_WIDTH  words not yet accepted downstream for the current transfer
- `fifo_rd_en`  out  1  FIFO read strobe (combinational)
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_underflow`  in  1  FIFO underflow indication
- `fifo_dout`  in  DATA_WIDTH  FIFO read data, valid the cycle after an accepted read
- `m_valid`  out  1  stream data valid
- `m_ready`  in  1  downstream ready
- `m_data`  out  DATA_WIDTH  stream data (buffer head, registered)
- `err_underflow`  out  1  sticky: FIFO reported underflow during operation

## Operation
- States: IDLE, READ, DRAIN.
  - IDLE: on `start`, load `issue_left` and `words_left` from `len`. If `len` != 0, go to READ. If `len` == 0, pulse `done` next cycle and stay IDLE.
  - READ: issue reads until `issue_left` == 0, then go to DRAIN.
  - DRAIN: wait until `words_left` == 0, then go to IDLE and pulse `done`.
- `fifo_rd_en = (state==READ) && !fifo_empty && issue_left != 0 && (occ + inflight) < 3`.
  - `occ` = buffer entries, 0..3. `inflight` = registered copy of last cycle's `fifo_rd_en`.
  - Each `fifo_rd_en` decrements `issue_left`.
- Capture: when `inflight`=1, push `fifo_dout` into the buffer tail.
- Pop: when `m_valid && m_ready`, remove head and decrement `words_left`.
- Push and pop in the same cycle: `occ` unchanged, FIFO order preserved.
- The credit rule guarantees the buffer never overflows. No push is ever dropped.
- `m_valid = (occ != 0)`. While `m_valid && !m_ready`, `m_data` is held stable.
- `start` while `busy` is ignored. `len` changes while busy have no effect.
- `err_underflow` sets on any cycle with `fifo_underflow`=1 and clears only on `rst`. The controller never reads an empty FIFO, so this flags an external violation.
- Counters are unsigned LEN_WIDTH. `issue_left` and `words_left` never wrap below 0.

## Timing
- Reset values: `busy`=0, `done`=0, `words_left`=0, `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `err_underflow`=0. State is IDLE, `occ`=0, `inflight`=0.
- `rst` mid-transfer: return to IDLE next cycle and discard buffer contents. A FIFO word read in the reset cycle is lost. No `done` pulse.
- Latency, FIFO non-empty, `start` sampled at edge t:
  - `busy`=1 from t+1.
  - `fifo_rd_en`=1 in cycle t+1.
  - Data captured at edge t+2.
  - `m_valid`=1 in cycle t+2 (after edge t+2).
- Throughput: with `m_ready`=1 and the FIFO never empty, one word per cycle after the first.
- FIFO goes empty mid-READ: `fifo_rd_en` drops the same cycle and resumes the cycle `fifo_empty` deasserts.
- `done` is asserted in the cycle after the edge where the last handshake occurs. `busy` is 0 in that same cycle. A new `start` is accepted in that cycle.

## Test plan
- FIFO preloaded with 8 words 0x0001..0x0008, `start` `len`=8, `m_ready`=1 -> `fifo_rd_en` high 8 consecutive cycles; `m_data` 0x0001..0x0008 in order on 8 consecutive valid cycles; `done` pulses once; `busy`=0 afterwards.
- Same preload, `m_ready` low for the first 10 cycles -> exactly 3 reads issued, `fifo_rd_en` stays 0 while `occ`+`inflight`=3, `m_data`=0x0001 held stable; after `m_ready`=1, all 8 words delivered in order.
- FIFO holds 2 words, `len`=5; 3 more words written 6 cycles later -> `fifo_rd_en`=0 while `fifo_empty`=1; `words_left` reaches 0 only after the fifth handshake; `done` follows.
- `start` with `len`=0 -> `done`=1 in the next cycle, `fifo_rd_en` never asserts, `busy` stays 0.
- `rst`=1 for 1 cycle after 3 of 8 words are delivered -> all outputs return to reset values next cycle; a new `start` `len`=2 then delivers the next 2 FIFO words correctly.
- Force `fifo_underflow`=1 for one cycle -> `err_underflow`=1 and stays 1 through later transfers until `rst`.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_read_ctrl
//
// Read-side controller for a synchronous FIFO. It drains a requested number
// of words from the FIFO and presents them on a valid/ready stream. The
// FIFO's one-cycle read latency is absorbed by a 3-entry output buffer. Each
// read is issued only when the buffer has room for it, counting the word
// still in flight from the previous cycle, so the buffer cannot overflow and
// one word per cycle is sustained while m_ready stays high.
//
// Parameters
//   DATA_WIDTH      width of FIFO read data and stream data
//   LEN_WIDTH       width of transfer length and remaining-word counters
//
// Ports
//   clk             clock, all logic on the rising edge
//   rst             synchronous active-high reset
//   start           one-cycle transfer request, honoured only while idle
//   len             transfer length in words, sampled together with start
//   busy            high while a transfer is in progress
//   done            one-cycle pulse when a transfer completes
//   words_left      words of the current transfer not yet accepted downstream
//   fifo_rd_en      FIFO read strobe (combinational)
//   fifo_empty      FIFO empty flag
//   fifo_underflow  FIFO underflow indication
//   fifo_dout       FIFO read data, valid the cycle after an accepted read
//   m_valid         stream data valid
//   m_ready         downstream ready
//   m_data          stream data, taken from the registered buffer head
//   err_underflow   sticky flag: the FIFO reported an underflow
// ---------------------------------------------------------------------------
module fifo_read_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  words_left,
    output logic                  fifo_rd_en,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  err_underflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = '0;
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [1:0]           BUF_DEPTH = 2'd3;

    state_t                state;
    logic [LEN_WIDTH-1:0]  issue_left;
    logic [1:0]            occ;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] obuf     [3];
    logic [DATA_WIDTH-1:0] obuf_nxt [3];
    logic [1:0]            occ_nxt;
    logic [1:0]            push_idx;
    logic [2:0]            credit_used;
    logic                  push;
    logic                  pop;

    // Buffer head is always entry 0, so the stream output comes straight
    // from a register and stays stable while the consumer stalls.
    assign busy    = (state != IDLE);
    assign m_valid = (occ != 2'd0);
    assign m_data  = obuf[0];

    assign push = inflight;
    assign pop  = m_valid && m_ready;

    // A read is allowed only if the word it returns is guaranteed a slot:
    // entries already held plus the word arriving this cycle must leave room.
    assign credit_used = {1'b0, occ} + {2'b00, inflight};
    assign fifo_rd_en  = (state == READ) && !fifo_empty &&
                         (issue_left != LEN_ZERO) && (credit_used < 3'd3);

    // Next buffer contents. A pop shifts everything one place toward the
    // head; an arriving word lands just behind the last valid entry, which
    // moves down by one when a pop happens in the same cycle.
    always_comb begin
        obuf_nxt = obuf;
        push_idx = occ;
        if (pop) begin
            obuf_nxt[0] = obuf[1];
            obuf_nxt[1] = obuf[2];
            push_idx    = occ - 2'd1;
        end
        if (push && (push_idx < BUF_DEPTH)) begin
            obuf_nxt[push_idx] = fifo_dout;
        end
    end

    always_comb begin
        occ_nxt = occ;
        case ({push, pop})
            2'b10:   occ_nxt = occ + 2'd1;
            2'b01:   occ_nxt = occ - 2'd1;
            default: occ_nxt = occ;
        endcase
    end

    // Control state, counters and buffer storage. Counter decrements are
    // written before the state case so that a load on start takes priority.
    // The transfer finishes on the edge of the final handshake, which makes
    // done and the return to IDLE visible in the very next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            issue_left    <= LEN_ZERO;
            words_left    <= LEN_ZERO;
            occ           <= 2'd0;
            inflight      <= 1'b0;
            done          <= 1'b0;
            err_underflow <= 1'b0;
            obuf          <= '{default: '0};
        end else begin
            done     <= 1'b0;
            inflight <= fifo_rd_en;
            occ      <= occ_nxt;
            obuf     <= obuf_nxt;

            if (fifo_underflow) begin
                err_underflow <= 1'b1;
            end

            if (fifo_rd_en) begin
                issue_left <= issue_left - LEN_ONE;
            end

            if (pop && (words_left != LEN_ZERO)) begin
                words_left <= words_left - LEN_ONE;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        issue_left <= len;
                        words_left <= len;
                        if (len != LEN_ZERO) begin
                            state <= READ;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end

                READ: begin
                    if (issue_left == LEN_ZERO) begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    if ((words_left == LEN_ZERO) ||
                        (pop && (words_left == LEN_ONE))) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_read_ctrl
//
// Bench for fifo_read_ctrl. A behavioural FIFO with one-cycle read latency
// feeds the controller. Words written to the FIFO carry a running sequence
// number; whenever a transfer is started, the words it must deliver are
// pushed onto a scoreboard queue, and every stream handshake pops and
// compares one entry.
// ---------------------------------------------------------------------------
module tb_fifo_read_ctrl;

    localparam int DW = 16;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic [LW-1:0] words_left;
    logic          fifo_rd_en;
    logic          fifo_empty;
    logic          fifo_underflow;
    logic [DW-1:0] fifo_dout = '0;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          err_underflow;

    int vectors    = 0;
    int miscompares = 0;

    logic [DW-1:0] fifo_mem [0:255];
    int            wr_ptr = 0;
    int            rd_ptr = 0;

    logic [DW-1:0] exp_q [$];
    int            next_val = 1;
    int            next_exp = 1;

    int rd_count   = 0;
    int rd_run     = 0;
    int rd_run_max = 0;
    int done_count = 0;
    int hs_count   = 0;

    fifo_read_ctrl #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .len            (len),
        .busy           (busy),
        .done           (done),
        .words_left     (words_left),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_dout      (fifo_dout),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .err_underflow  (err_underflow)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous FIFO: data appears the cycle after a read.
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] expected);
        vectors++;
        if (got !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifoWrite(input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr] = next_val[DW-1:0];
            wr_ptr   = wr_ptr + 1;
            next_val = next_val + 1;
        end
    endtask

    // Request a transfer of n words; the expected words are the next n in
    // FIFO order. Returns one time unit after the edge that samples start.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(next_exp[DW-1:0]);
            next_exp = next_exp + 1;
        end
        len   = n[LW-1:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        len   = LW'($urandom_range(0, 255));
    endtask

    task automatic waitDone(input string tag, input int budget);
        int seen = 0;
        for (int i = 0; i < budget && seen == 0; i++) begin
            @(posedge clk);
            #2;
            if (done) seen = 1;
        end
        checkOutput(tag, seen, 1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"},       busy,          0);
        checkOutput({tag, "_done"},       done,          0);
        checkOutput({tag, "_words_left"}, words_left,    0);
        checkOutput({tag, "_rd_en"},      fifo_rd_en,    0);
        checkOutput({tag, "_m_valid"},    m_valid,       0);
        checkOutput({tag, "_m_data"},     m_data,        0);
        checkOutput({tag, "_err"},        err_underflow, 0);
    endtask

    // Monitor: read activity, done pulses and the stream scoreboard.
    always @(negedge clk) begin
        if (fifo_rd_en) begin
            rd_count++;
            rd_run++;
            if (rd_run > rd_run_max) rd_run_max = rd_run;
        end else begin
            rd_run = 0;
        end
        checkOutput("rd_while_empty", {31'b0, fifo_rd_en && fifo_empty}, 0);
        if (done) begin
            done_count++;
            checkOutput("busy_at_done", busy, 0);
        end
        if (m_valid && m_ready) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                checkOutput("sb_extra_word", exp_q.size(), 1);
            end else begin
                checkOutput("words_left_at_hs", words_left, exp_q.size());
                checkOutput("m_data", m_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rd0;
        int d0;
        int h0;
        int base;

        rst            = 1'b1;
        start          = 1'b0;
        len            = '0;
        m_ready        = 1'b0;
        fifo_underflow = 1'b0;

        repeat (2) @(posedge clk);
        #2;
        checkResetValues("reset");
        rst = 1'b0;
        tick();

        // Full-rate transfer of 8 preloaded words.
        $display("[TB] full-rate transfer");
        fifoWrite(8);
        m_ready    = 1'b1;
        rd0        = rd_count;
        d0         = done_count;
        rd_run_max = 0;
        applyStimulus(8);
        #1;
        checkOutput("t1_busy",       busy,       1);
        checkOutput("t1_rd_first",   fifo_rd_en, 1);
        checkOutput("t1_valid_t1",   m_valid,    0);
        tick(); #1;
        checkOutput("t1_valid_t2",   m_valid,    0);
        tick(); #1;
        checkOutput("t1_valid_t3",   m_valid,    1);
        checkOutput("t1_first_word", m_data,     16'h0001);
        waitDone("t1_done", 100);
        checkOutput("t1_busy_end",   busy,       0);
        repeat (3) tick();
        checkOutput("t1_rd_total",   rd_count - rd0,   8);
        checkOutput("t1_rd_run",     rd_run_max,       8);
        checkOutput("t1_done_once",  done_count - d0,  1);
        checkOutput("t1_sb_empty",   exp_q.size(),     0);

        // Stalled consumer: only three reads may be outstanding.
        $display("[TB] stalled consumer");
        fifoWrite(8);
        m_ready = 1'b0;
        rd0     = rd_count;
        base    = next_exp;
        applyStimulus(8);
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            if (i >= 1) begin
                checkOutput("t2_valid_held", m_valid, 1);
                checkOutput("t2_data_held",  m_data,  base);
            end
        end
        checkOutput("t2_rd_stalled", rd_count - rd0, 3);
        checkOutput("t2_words_left", words_left, 8);
        m_ready = 1'b1;
        waitDone("t2_done", 100);
        repeat (2) tick();
        checkOutput("t2_rd_total",   rd_count - rd0, 8);
        checkOutput("t2_sb_empty",   exp_q.size(),   0);

        // FIFO runs dry mid-transfer and is refilled later.
        $display("[TB] FIFO starvation");
        fifoWrite(2);
        rd0 = rd_count;
        applyStimulus(5);
        repeat (6) tick();
        #1;
        checkOutput("t3_rd_starved",   rd_count - rd0, 2);
        checkOutput("t3_words_left",   words_left,     3);
        checkOutput("t3_busy_starved", busy,           1);
        fifoWrite(3);
        waitDone("t3_done", 100);
        checkOutput("t3_words_left_end", words_left,   0);
        repeat (2) tick();
        checkOutput("t3_rd_total",     rd_count - rd0, 5);

        // Zero-length request completes immediately.
        $display("[TB] zero-length transfer");
        rd0 = rd_count;
        d0  = done_count;
        applyStimulus(0);
        #1;
        checkOutput("t4_done",  done,       1);
        checkOutput("t4_busy",  busy,       0);
        checkOutput("t4_rd_en", fifo_rd_en, 0);
        repeat (3) tick();
        checkOutput("t4_busy_after", busy,           0);
        checkOutput("t4_rd_none",    rd_count - rd0, 0);
        checkOutput("t4_done_once",  done_count - d0, 1);

        // Reset in the middle of a transfer, then resume with a new one.
        $display("[TB] mid-transfer reset");
        fifoWrite(8);
        m_ready = 1'b1;
        rd0     = rd_count;
        d0      = done_count;
        h0      = hs_count;
        base    = next_exp;
        applyStimulus(8);
        for (int i = 0; i < 50 && (hs_count - h0) < 3; i++) tick();
        m_ready = 1'b0;
        checkOutput("t5_hs_three", hs_count - h0, 3);
        repeat (6) tick();
        #1;
        checkOutput("t5_words_left", words_left,     5);
        checkOutput("t5_rd_count",   rd_count - rd0, 6);
        checkOutput("t5_head",       m_data,         base + 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkResetValues("t5_rst");
        exp_q.delete();
        next_exp = base + 6;
        m_ready  = 1'b1;
        applyStimulus(2);
        waitDone("t5_done", 100);
        repeat (2) tick();
        checkOutput("t5_done_once", done_count - d0, 1);
        checkOutput("t5_sb_empty",  exp_q.size(),    0);

        // Sticky underflow flag survives transfers and clears on reset.
        $display("[TB] underflow flag");
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        #1;
        checkOutput("t6_err_set", err_underflow, 1);
        fifoWrite(2);
        applyStimulus(2);
        waitDone("t6_done", 100);
        checkOutput("t6_err_sticky", err_underflow, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("t6_err_cleared", err_underflow, 0);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
